// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and sizes for the pre-buffer scheduler
package snn_pkg;

  localparam int N_BEATS = 144;
  localparam int SPIKE_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_INIT_WAIT,
    S_FILL,
    S_KICK,
    S_STREAM,
    S_STEP_WAIT,
    S_STDP,
    S_STDP_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/spike_stage_buf.sv
// rtl/spike_stage_buf.sv - DEPTH x W write-then-read stage buffer, registered read data
module spike_stage_buf
  import snn_pkg::*;
#(
  parameter int DEPTH = N_BEATS,
  parameter int W     = SPIKE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_almost_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_rd_data;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full        = (r_count == CW'(DEPTH));
  assign o_almost_full = (r_count == CW'(DEPTH - 1));
  assign o_empty       = (r_count == '0);
  assign w_wr          = i_wr_en && !o_full;
  assign w_rd          = i_rd_en && !o_empty;
  assign o_rd_data     = r_rd_data;

  // Storage and read register are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/prebuf_sched.sv
// rtl/prebuf_sched.sv - timestep scheduler feeding the pre-buffer; watchdog under PREBUF_SCHED_WATCHDOG_EN
module prebuf_sched
  import snn_pkg::*;
#(
  parameter int N_BEATS = snn_pkg::N_BEATS,
  parameter int STEP_W  = 8,
  parameter int WDOG_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_num_steps,
  input  logic              i_learn_en,
  input  logic [3:0]        i_spike,
  input  logic              i_spike_valid,
  output logic              o_spike_ready,
  output logic              o_pb_init,
  output logic              o_pb_b_run,
  output logic              o_pb_valid,
  output logic [3:0]        o_pb_spike,
  output logic              o_pb_stdp_run,
  input  logic              i_pb_done,
  output logic [STEP_W-1:0] o_step_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  state_t            r_state;
  state_t            w_next;
  logic [STEP_W-1:0] r_num_steps;
  logic              r_learn;
  logic [STEP_W-1:0] r_step_cnt;
  logic              r_pb_init;
  logic              r_pb_b_run;
  logic              r_pb_valid;
  logic [3:0]        r_pb_spike;
  logic              r_pb_stdp_run;
  logic              r_done;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [3:0]        w_rd_data;
  logic              w_full;
  logic              w_almost_full;
  logic              w_empty;
  logic              w_wait;
  logic              w_wdog_hit;

  assign w_wr_en = (r_state == S_FILL) && i_spike_valid && !w_full;
  // Read one ahead from KICK so each STREAM cycle already has its beat.
  assign w_rd_en = (r_state == S_KICK) || ((r_state == S_STREAM) && !w_empty);
  assign w_wait  = (r_state == S_INIT_WAIT) || (r_state == S_STEP_WAIT) ||
                   (r_state == S_STDP_WAIT);

  spike_stage_buf #(
    .DEPTH (N_BEATS),
    .W     (4)
  ) u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (w_wr_en),
    .i_wr_data     (i_spike),
    .i_rd_en       (w_rd_en),
    .o_rd_data     (w_rd_data),
    .o_full        (w_full),
    .o_almost_full (w_almost_full),
    .o_empty       (w_empty)
  );

`ifdef PREBUF_SCHED_WATCHDOG_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              r_error;

  assign w_wdog_hit = w_wait && !i_pb_done && (&r_wdog);
  assign o_error    = r_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog  <= '0;
      r_error <= 1'b0;
    end else begin
      r_wdog <= (w_wait && !i_pb_done) ? r_wdog + WDOG_W'(1) : '0;
      if (w_wdog_hit) r_error <= 1'b1;
      else if ((r_state == S_IDLE) && i_start) r_error <= 1'b0;
    end
  end
`else
  // Constant false; also keeps WDOG_W referenced when no watchdog is built.
  assign w_wdog_hit = (WDOG_W < 0);
  assign o_error    = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_start) w_next = (i_num_steps == '0) ? S_DONE : S_INIT;
      S_INIT:      w_next = S_INIT_WAIT;
      S_INIT_WAIT: if (i_pb_done) w_next = S_FILL;
      S_FILL:      if (w_wr_en && w_almost_full) w_next = S_KICK;
      S_KICK:      w_next = S_STREAM;
      S_STREAM:    if (w_empty) w_next = S_STEP_WAIT;
      S_STEP_WAIT: if (i_pb_done) w_next = r_learn ? S_STDP : S_NEXT;
      S_STDP:      w_next = S_STDP_WAIT;
      S_STDP_WAIT: if (i_pb_done) w_next = S_NEXT;
      S_NEXT:      w_next = (r_step_cnt == r_num_steps) ? S_DONE : S_FILL;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (w_wdog_hit) w_next = S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_num_steps   <= '0;
      r_learn       <= 1'b0;
      r_step_cnt    <= '0;
      r_pb_init     <= 1'b0;
      r_pb_b_run    <= 1'b0;
      r_pb_valid    <= 1'b0;
      r_pb_spike    <= '0;
      r_pb_stdp_run <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && i_start && (i_num_steps != '0)) begin
        r_num_steps <= i_num_steps;
        r_learn     <= i_learn_en;
        r_step_cnt  <= '0;
      end else if ((r_state == S_STEP_WAIT) && i_pb_done) begin
        r_step_cnt <= r_step_cnt + STEP_W'(1);
      end
      // Outputs are registered decodes of the current state, one cycle behind it.
      r_pb_init     <= (r_state == S_INIT);
      r_pb_b_run    <= (r_state == S_KICK);
      r_pb_stdp_run <= (r_state == S_STDP);
      r_done        <= (r_state == S_DONE);
      r_pb_valid    <= (r_state == S_STREAM);
      r_pb_spike    <= (r_state == S_STREAM) ? w_rd_data : '0;
    end
  end

  assign o_spike_ready = (r_state == S_FILL) && !w_full;
  assign o_pb_init     = r_pb_init;
  assign o_pb_b_run    = r_pb_b_run;
  assign o_pb_valid    = r_pb_valid;
  assign o_pb_spike    = r_pb_spike;
  assign o_pb_stdp_run = r_pb_stdp_run;
  assign o_step_cnt    = r_step_cnt;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;

endmodule

// File: tb/tb_prebuf_sched.sv
// tb/tb_prebuf_sched.sv - directed self-checking bench for prebuf_sched
module tb_prebuf_sched;

  localparam int NB     = 144;
  localparam int STEP_W = 8;
  localparam int WDOG_W = 4;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic [STEP_W-1:0] i_num_steps;
  logic              i_learn_en;
  logic [3:0]        i_spike;
  logic              i_spike_valid;
  logic              o_spike_ready;
  logic              o_pb_init;
  logic              o_pb_b_run;
  logic              o_pb_valid;
  logic [3:0]        o_pb_spike;
  logic              o_pb_stdp_run;
  logic              i_pb_done;
  logic [STEP_W-1:0] o_step_cnt;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  prebuf_sched #(
    .N_BEATS (NB),
    .STEP_W  (STEP_W),
    .WDOG_W  (WDOG_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_num_steps   (i_num_steps),
    .i_learn_en    (i_learn_en),
    .i_spike       (i_spike),
    .i_spike_valid (i_spike_valid),
    .o_spike_ready (o_spike_ready),
    .o_pb_init     (o_pb_init),
    .o_pb_b_run    (o_pb_b_run),
    .o_pb_valid    (o_pb_valid),
    .o_pb_spike    (o_pb_spike),
    .o_pb_stdp_run (o_pb_stdp_run),
    .i_pb_done     (i_pb_done),
    .o_step_cnt    (o_step_cnt),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int c_init, c_brun, c_stdp, c_done, c_accept, c_excl_bad, c_zero_bad;

  always @(negedge clk) begin
    if (o_pb_init)     c_init++;
    if (o_pb_b_run)    c_brun++;
    if (o_pb_stdp_run) c_stdp++;
    if (o_done)        c_done++;
    if (i_spike_valid && o_spike_ready) c_accept++;
    if ($countones({o_pb_init, o_pb_b_run, o_pb_stdp_run, o_done}) > 1) c_excl_bad++;
    if (!o_pb_valid && (o_pb_spike != 4'd0)) c_zero_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    c_init = 0; c_brun = 0; c_stdp = 0; c_done = 0; c_accept = 0;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return o_pb_init;
      1:       return o_pb_b_run;
      2:       return o_pb_stdp_run;
      default: return o_done;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, input int limit);
    int n = 0;
    while ((sel(which) !== 1'b1) && (n < limit)) begin
      tick();
      n++;
    end
    chk(tag, 32'(sel(which)), 32'd1);
  endtask

  task automatic pb_done_pulse();
    i_pb_done = 1'b1;
    tick();
    i_pb_done = 1'b0;
  endtask

  task automatic start_run(input int steps, input bit learn);
    i_num_steps = STEP_W'(steps);
    i_learn_en  = learn;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic fill(input string tag, input int off, input bit bp);
    int k = 0;
    int cyc = 0;
    bit v;
    while ((k < NB) && (cyc < 2000)) begin
      v = bp ? (cyc % 2 == 0) : 1'b1;
      i_spike_valid = v;
      i_spike       = 4'((k + off) % 16);
      if (v && o_spike_ready) k++;
      tick();
      cyc++;
    end
    i_spike_valid = 1'b0;
    chk({tag, "_fill_count"}, 32'(k), 32'(NB));
    chk({tag, "_ready_low_full"}, 32'(o_spike_ready), 32'd0);
  endtask

  task automatic stream(input string tag, input int off);
    int bad = 0;
    wait_sig({tag, "_brun_seen"}, 1, 10);
    tick();
    for (int k = 0; k < NB; k++) begin
      if ((o_pb_valid !== 1'b1) || (o_pb_spike !== 4'((k + off) % 16))) bad++;
      tick();
    end
    chk({tag, "_stream_bad_beats"}, 32'(bad), 32'd0);
    chk({tag, "_valid_after_last"}, 32'(o_pb_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_num_steps = '0; i_learn_en = 1'b0;
    i_spike = '0; i_spike_valid = 1'b0; i_pb_done = 1'b0;
    c_excl_bad = 0; c_zero_bad = 0;
    clr_counts();
    tick(); tick();
    chk("reset_outputs", 32'({o_spike_ready, o_pb_init, o_pb_b_run, o_pb_valid, o_pb_spike,
                               o_pb_stdp_run, o_step_cnt, o_busy, o_done, o_error}), 32'd0);
    rst_n = 1'b1;
    tick();

    // single step, no learning
    clr_counts();
    start_run(1, 1'b0);
    chk("t1_busy", 32'(o_busy), 32'd1);
    wait_sig("t1_init_seen", 0, 5);
    pb_done_pulse();
    fill("t1", 0, 1'b0);
    stream("t1", 0);
    pb_done_pulse();
    wait_sig("t1_done_seen", 3, 8);
    chk("t1_step_cnt", 32'(o_step_cnt), 32'd1);
    tick();
    chk("t1_init_pulses", 32'(c_init), 32'd1);
    chk("t1_brun_pulses", 32'(c_brun), 32'd1);
    chk("t1_done_pulses", 32'(c_done), 32'd1);
    chk("t1_idle", 32'({o_busy, o_done}), 32'd0);

    // source backpressure plus a start pulse while busy
    clr_counts();
    start_run(1, 1'b0);
    wait_sig("t2_init_seen", 0, 5);
    start_run(0, 1'b0);
    pb_done_pulse();
    fill("t2", 3, 1'b1);
    chk("t2_accepted", 32'(c_accept), 32'(NB));
    stream("t2", 3);
    pb_done_pulse();
    wait_sig("t2_done_seen", 3, 8);
    chk("t2_step_cnt", 32'(o_step_cnt), 32'd1);
    tick();
    chk("t2_done_pulses", 32'(c_done), 32'd1);

    // learning over three steps
    clr_counts();
    start_run(3, 1'b1);
    wait_sig("t3_init_seen", 0, 5);
    pb_done_pulse();
    for (int s = 0; s < 3; s++) begin
      fill("t3", s * 5, 1'b0);
      stream("t3", s * 5);
      chk("t3_stdp_before_done", 32'(c_stdp), 32'(s));
      pb_done_pulse();
      wait_sig("t3_stdp_seen", 2, 5);
      pb_done_pulse();
    end
    wait_sig("t3_done_seen", 3, 8);
    chk("t3_step_cnt", 32'(o_step_cnt), 32'd3);
    tick();
    chk("t3_stdp_pulses", 32'(c_stdp), 32'd3);
    chk("t3_brun_pulses", 32'(c_brun), 32'd3);
    chk("t3_done_pulses", 32'(c_done), 32'd1);

    // zero-step run
    clr_counts();
    i_num_steps = '0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t4_done_early", 32'(o_done), 32'd0);
    tick();
    chk("t4_done_at_2", 32'(o_done), 32'd1);
    tick();
    chk("t4_no_pb_pulses", 32'(c_init + c_brun + c_stdp), 32'd0);
    chk("t4_done_pulses", 32'(c_done), 32'd1);

    // asynchronous reset mid-stream, then a fresh run
    start_run(1, 1'b0);
    wait_sig("t5_init_seen", 0, 5);
    pb_done_pulse();
    fill("t5", 7, 1'b0);
    wait_sig("t5_brun_seen", 1, 10);
    tick();
    for (int k = 0; k < 70; k++) tick();
    chk("t5_mid_stream_valid", 32'(o_pb_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", 32'({o_spike_ready, o_pb_init, o_pb_b_run, o_pb_valid, o_pb_spike,
                                  o_pb_stdp_run, o_step_cnt, o_busy, o_done, o_error}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clr_counts();
    start_run(1, 1'b0);
    wait_sig("t5b_init_seen", 0, 5);
    pb_done_pulse();
    fill("t5b", 9, 1'b0);
    stream("t5b", 9);
    pb_done_pulse();
    wait_sig("t5b_done_seen", 3, 8);
    chk("t5b_step_cnt", 32'(o_step_cnt), 32'd1);
    tick();

`ifdef PREBUF_SCHED_WATCHDOG_EN
    // pre-buffer never answers the step
    clr_counts();
    start_run(1, 1'b0);
    wait_sig("t6_init_seen", 0, 5);
    pb_done_pulse();
    fill("t6", 0, 1'b0);
    stream("t6", 0);
    wait_sig("t6_done_seen", 3, 40);
    chk("t6_error_set", 32'(o_error), 32'd1);
    tick();
    start_run(1, 1'b0);
    chk("t6_error_cleared", 32'(o_error), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    chk("mutual_exclusion", 32'(c_excl_bad), 32'd0);
    chk("spike_zero_when_idle", 32'(c_zero_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prebuf_sched.md
PREBUF_SCHED -- requirements
Module: prebuf_sched

Interface
REQ-001 Parameter N_BEATS, default 144, meaning: 4-bit spike beats per timestep (24x24 map / 4).
REQ-002 Parameter STEP_W, default 8, meaning: width of the timestep count.
REQ-003 Parameter WDOG_W, default 16, meaning: width of the done-wait watchdog counter.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- i_start, in, 1: start-of-run pulse.
- i_num_steps, in, STEP_W: timestep count, sampled at start.
- i_learn_en, in, 1: run STDP after each step, sampled at start.
- i_spike, in, 4: spike beat from the source.
- i_spike_valid, in, 1: beat valid.
- o_spike_ready, out, 1: beat accepted when valid and ready are both high.
- o_pb_init, out, 1: pulse to pre-buffer init.
- o_pb_b_run, out, 1: pulse to pre-buffer stack.
- o_pb_valid, out, 1: pre-buffer beat valid.
- o_pb_spike, out, 4: pre-buffer beat.
- o_pb_stdp_run, out, 1: pulse to pre-buffer send-only.
- i_pb_done, in, 1: pre-buffer done pulse.
- o_step_cnt, out, STEP_W: completed timesteps.
- o_busy, out, 1: not IDLE.
- o_done, out, 1: one-cycle run-complete pulse.
- o_error, out, 1: sticky watchdog error.

Function
REQ-005 States: IDLE, INIT, INIT_WAIT, FILL, KICK, STREAM, STEP_WAIT, STDP, STDP_WAIT, NEXT, DONE.
REQ-006 IDLE, on i_start with i_num_steps not equal to 0: latch the count and learn flag, clear o_step_cnt, go to INIT. If i_num_steps is 0: go straight to DONE.
REQ-007 INIT: assert o_pb_init for exactly 1 cycle, then INIT_WAIT. INIT_WAIT exits to FILL on i_pb_done.
REQ-008 FILL: o_spike_ready is high while the stage buffer holds fewer than N_BEATS beats. Each handshake writes one beat. When the N_BEATS-th beat is accepted, go to KICK. Ready drops in the same cycle the buffer becomes full.
REQ-009 KICK: assert o_pb_b_run for 1 cycle, then STREAM.
REQ-010 STREAM: the first cycle is the cycle after KICK. Assert o_pb_valid on exactly N_BEATS consecutive cycles, with no gaps. Beats leave in arrival order (first accepted beat first). After the last beat, go to STEP_WAIT.
REQ-011 STEP_WAIT: on i_pb_done, increment o_step_cnt. Then go to STDP if learn is latched, else NEXT.
REQ-012 STDP: pulse o_pb_stdp_run for 1 cycle, then STDP_WAIT. STDP_WAIT exits to NEXT on i_pb_done.
REQ-013 NEXT: go to DONE if o_step_cnt equals the latched count, else FILL.
REQ-014 DONE: o_done is high for 1 cycle, then IDLE.
REQ-015 i_start outside IDLE is ignored. i_pb_done outside the *_WAIT states is ignored.
REQ-016 o_pb_spike is 0 whenever o_pb_valid is low.
REQ-017 All pulse outputs are registered and mutually exclusive.
REQ-018 o_spike_ready is low outside FILL.
REQ-019 o_busy equals (state != IDLE).
REQ-020 o_step_cnt wraps modulo 2^STEP_W. No saturation is needed, because the count is bounded by the latched i_num_steps.

Reset
REQ-021 Asynchronous assertion of rst_n forces IDLE at any point, including mid-FILL or mid-STREAM.
REQ-022 Reset clears the buffer pointers and all counters.
REQ-023 Reset drives every output to 0.
REQ-024 Stage buffer contents are not reset. Only the pointers are reset.

Configuration
REQ-025 Macro PREBUF_SCHED_WATCHDOG_EN.
- Defined: a WDOG_W-bit counter runs in INIT_WAIT, STEP_WAIT and STDP_WAIT. On reaching all-ones it sets o_error, pulses o_done, and returns to IDLE. o_error clears on the next accepted i_start.
- Undefined: the counter is not built, the wait states wait indefinitely, and o_error is tied to 0.

Structure
REQ-026 Shared package snn_pkg holds:
- the state enum typedef;
- N_BEATS = 144;
- the spike beat width of 4.
REQ-027 Sub-module spike_stage_buf: an N_BEATS x 4 write-then-read buffer with wr_en, rd_en, full and empty. It is implemented as registers or inferred RAM with 1-cycle read latency, prefetched so that STREAM has no gaps.

Verification
REQ-028 Single step: num_steps=1, learn=0, 144 beats with value (k mod 16).
- o_pb_init pulses once.
- b_run pulses once.
- o_pb_valid is high on 144 consecutive cycles starting 1 cycle after b_run, with payload 0,1,...,15 repeating.
- o_done pulses after the done response; step_cnt=1.
REQ-029 Source backpressure: valid toggles 1-0-1 during FILL.
- Exactly 144 beats are accepted.
- ready goes low after beat 144.
- The STREAM sequence matches the input with no gaps.
REQ-030 Learn: num_steps=3, learn=1.
- Ordering per step is b_run, done, stdp_run, done.
- 3 stdp_run pulses in total.
- step_cnt ends at 3; o_done pulses once.
REQ-031 Corner cases:
- num_steps=0: o_done pulses 2 cycles after i_start, with no pb pulses.
- i_start asserted mid-run: ignored.
REQ-032 Reset during STREAM at beat 70:
- All outputs are 0 at once.
- A subsequent run with num_steps=1 streams a fresh 144 beats correctly.
REQ-033 Watchdog (PREBUF_SCHED_WATCHDOG_EN defined, WDOG_W=4): the pre-buffer model never returns done.
- o_error=1 and o_done pulses 15 cycles into STEP_WAIT.
- The next i_start clears o_error.
